ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter BITS_SIZE, default 32, operand/HI/LO width (even, >=8).
REQ-002 SHALL have parameter BITS_CORTOCIRCUITO, default 3, forwarding-select width.
REQ-003 SHALL have parameter BITS_MDOP, default 3, operation-code width.
REQ-004 SHALL have port i_clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port i_reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_start  in  1  operation request from ID/EX, one cycle.
REQ-007 SHALL have port i_md_op  in  BITS_MDOP  op: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
REQ-008 SHALL have ports i_corto_register_A / i_corto_register_B  in  BITS_CORTOCIRCUITO  operand forwarding selects.
REQ-009 SHALL have ports i_register1 / i_register2  in  BITS_SIZE  ID/EX rs / rt values.
REQ-010 SHALL have ports i_exmem_register / i_wb_data_write  in  BITS_SIZE  EX/MEM and MEM/WB forwarded values.
REQ-011 SHALL have port i_flush  in  1  abort in-flight operation.
REQ-012 SHALL have ports o_hi / o_lo  out  BITS_SIZE  architectural HI/LO (MFHI/MFLO source).
REQ-013 SHALL have ports o_busy, o_stall, o_done, o_illegal  out  1  status (defined below).

Function
REQ-014 Operand select SHALL be: 000 register, 001 exmem, 010 memwb, others register; operands latched only on accepted i_start.
REQ-015 FSM states SHALL be IDLE, RUN, FIX; i_start accepted only in IDLE.
REQ-016 Accepted MULT/MULTU/DIV/DIVU SHALL go IDLE->RUN, stay BITS_SIZE cycles (radix-2 shift-add / restoring divide), then FIX one cycle, then IDLE.
REQ-017 FIX SHALL apply sign correction (signed ops use magnitudes in RUN) and write HI/LO at the FIX->IDLE edge.
REQ-018 Multiply SHALL produce full 2*BITS_SIZE product: HI upper half, LO lower half.
REQ-019 Divide SHALL produce LO=quotient truncated toward zero, HI=remainder with dividend's sign.
REQ-020 Divide-by-zero SHALL yield LO=all ones, HI=dividend, no exception.
REQ-021 Signed overflow (most-negative / -1) SHALL yield LO=most-negative, HI=0.
REQ-022 o_busy SHALL be high in RUN and FIX (BITS_SIZE+1 cycles per op).
REQ-023 o_stall SHALL be combinational: o_busy OR (i_start AND long op AND IDLE).
REQ-024 o_done SHALL pulse one cycle, the first IDLE cycle after FIX.
REQ-025 MTHI/MTLO in IDLE SHALL write forwarded operand A to HI/LO at the next edge, no busy, no done.
REQ-026 i_start while busy SHALL be ignored; pipeline is held by o_stall.
REQ-027 i_flush SHALL force IDLE next edge, HI/LO unchanged, no o_done; flush wins over simultaneous i_start.
REQ-028 Opcodes 000/111 with i_start SHALL be no-ops.

Reset
REQ-029 i_reset low SHALL immediately force IDLE, o_hi=o_lo=0, o_busy=o_done=o_illegal=0, regardless of op in flight.
REQ-030 o_stall SHALL be 0 during reset; first start accepted on first edge after release.

Configuration
REQ-031 Macro MULDIV_DIVIDE_EN SHALL gate the divider datapath.
REQ-032 With MULDIV_DIVIDE_EN defined: DIV/DIVU behave per REQ-016..021; o_illegal tied 0.
REQ-033 Without it: DIV/DIVU SHALL not enter RUN, leave HI/LO unchanged, assert no stall, and pulse o_illegal one cycle after i_start.

Verification
REQ-034 MULT A=0xFFFFFFFE, B=0x00000003 -> o_busy 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, o_done pulse.
REQ-035 MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-036 DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=5, B=0 -> LO=0xFFFFFFFF, HI=0x00000005.
REQ-037 MULT with select A=001 (exmem=4), B=010 (memwb=5), registers 0 -> LO=20, HI=0.
REQ-038 i_flush at RUN cycle 10, then i_reset low at RUN cycle 5 of next op -> IDLE, no o_done, HI/LO prior / 0 respectively.
REQ-039 Build without MULDIV_DIVIDE_EN, issue DIV -> o_illegal one pulse, o_stall 0, HI/LO unchanged.

Source files
------------

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative multiply/divide unit with architectural HI/LO
//
// Purpose: radix-2 shift-add multiplier and restoring divider for the EX stage.
//   A long op runs BITS_SIZE cycles in RUN and one cycle in FIX, which applies
//   sign correction and writes HI/LO. MTHI/MTLO write HI/LO directly from IDLE.
// Configuration: define MULDIV_DIVIDE_EN to enable DIV/DIVU. Without it,
//   DIV/DIVU are rejected with a one-cycle o_illegal pulse.
// Ports:
//   i_clk, i_reset (async active-low)
//   i_start, i_md_op                        operation request
//   i_corto_register_A/B                    forwarding selects for operands A/B
//   i_register1/2, i_exmem_register,
//   i_wb_data_write                         operand sources
//   i_flush                                 abort in-flight op
//   o_hi, o_lo                              architectural HI/LO
//   o_busy, o_stall, o_done, o_illegal      status
module ex_muldiv #(
    parameter int BITS_SIZE          = 32,
    parameter int BITS_CORTOCIRCUITO = 3,
    parameter int BITS_MDOP          = 3
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [BITS_MDOP-1:0]          i_md_op,
    input  logic [BITS_CORTOCIRCUITO-1:0] i_corto_register_A,
    input  logic [BITS_CORTOCIRCUITO-1:0] i_corto_register_B,
    input  logic [BITS_SIZE-1:0]          i_register1,
    input  logic [BITS_SIZE-1:0]          i_register2,
    input  logic [BITS_SIZE-1:0]          i_exmem_register,
    input  logic [BITS_SIZE-1:0]          i_wb_data_write,
    input  logic                          i_flush,
    output logic [BITS_SIZE-1:0]          o_hi,
    output logic [BITS_SIZE-1:0]          o_lo,
    output logic                          o_busy,
    output logic                          o_stall,
    output logic                          o_done,
    output logic                          o_illegal
);
    localparam int N  = BITS_SIZE;
    localparam int CW = $clog2(BITS_SIZE);

`ifdef MULDIV_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [BITS_MDOP-1:0] OP_MULT  = BITS_MDOP'(1);
    localparam logic [BITS_MDOP-1:0] OP_MULTU = BITS_MDOP'(2);
    localparam logic [BITS_MDOP-1:0] OP_DIV   = BITS_MDOP'(3);
    localparam logic [BITS_MDOP-1:0] OP_DIVU  = BITS_MDOP'(4);
    localparam logic [BITS_MDOP-1:0] OP_MTHI  = BITS_MDOP'(5);
    localparam logic [BITS_MDOP-1:0] OP_MTLO  = BITS_MDOP'(6);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t         state_q;
    logic [N-1:0]   hi_q, lo_q;
    logic [N-1:0]   mcand_q;      // multiplicand or divisor magnitude
    logic [N-1:0]   dividend_q;   // raw dividend, needed for divide-by-zero HI
    logic [2*N-1:0] prod_q;       // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [CW-1:0]  cnt_q;
    logic           is_div_q, neg_q, rem_neg_q, div_zero_q;
    logic           done_q, illegal_q;

    logic [N-1:0]   opa, opb, a_mag, b_mag;
    logic           op_signed, op_mul, op_div, op_div_en;
    logic [N:0]     mul_sum;
    logic [N+1:0]   div_diff;
    logic [2*N-1:0] prod_d, mul_res;
    logic [N-1:0]   quo_fix, rem_fix, hi_d, lo_d;

    function automatic logic [N-1:0] fwd_sel(
        input logic [BITS_CORTOCIRCUITO-1:0] sel,
        input logic [N-1:0]                  reg_v,
        input logic [N-1:0]                  exm_v,
        input logic [N-1:0]                  wb_v
    );
        case (sel)
            BITS_CORTOCIRCUITO'(1): return exm_v;
            BITS_CORTOCIRCUITO'(2): return wb_v;
            default:                return reg_v;
        endcase
    endfunction

    // Operand selection and magnitude conversion for the request in IDLE.
    always_comb begin
        opa       = fwd_sel(i_corto_register_A, i_register1, i_exmem_register, i_wb_data_write);
        opb       = fwd_sel(i_corto_register_B, i_register2, i_exmem_register, i_wb_data_write);
        op_signed = (i_md_op == OP_MULT) || (i_md_op == OP_DIV);
        a_mag     = (op_signed && opa[N-1]) ? -opa : opa;
        b_mag     = (op_signed && opb[N-1]) ? -opb : opb;
        op_mul    = (i_md_op == OP_MULT) || (i_md_op == OP_MULTU);
        op_div    = (i_md_op == OP_DIV) || (i_md_op == OP_DIVU);
        op_div_en = DIV_EN && op_div;
    end

    // One iteration step, plus the FIX-stage signed results.
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
        // Shifted partial remainder (N+1 bits) minus divisor; sign bit set means restore.
        div_diff = {1'b0, prod_q[2*N-1:N-1]} - {2'b00, mcand_q};
        if (is_div_q) begin
            if (!div_diff[N+1]) begin
                prod_d = {div_diff[N-1:0], prod_q[N-2:0], 1'b1};
            end else begin
                prod_d = {prod_q[2*N-2:0], 1'b0};
            end
        end else begin
            prod_d = {mul_sum, prod_q[N-1:1]};
        end

        mul_res = neg_q ? -prod_q : prod_q;
        quo_fix = neg_q ? -prod_q[N-1:0] : prod_q[N-1:0];
        rem_fix = rem_neg_q ? -prod_q[2*N-1:N] : prod_q[2*N-1:N];
        // Most-negative / -1 needs no special case: the magnitude quotient
        // 2^(N-1) with positive sign already has the most-negative bit pattern.
        if (is_div_q) begin
            if (div_zero_q) begin
                hi_d = dividend_q;
                lo_d = {N{1'b1}};
            end else begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end
        end else begin
            hi_d = mul_res[2*N-1:N];
            lo_d = mul_res[N-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            mcand_q    <= '0;
            dividend_q <= '0;
            prod_q     <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!i_flush && i_start) begin
                        if (op_mul || op_div_en) begin
                            state_q    <= S_RUN;
                            prod_q     <= {{N{1'b0}}, a_mag};
                            mcand_q    <= b_mag;
                            dividend_q <= opa;
                            cnt_q      <= '0;
                            is_div_q   <= op_div;
                            neg_q      <= op_signed && (opa[N-1] ^ opb[N-1]);
                            rem_neg_q  <= op_signed && opa[N-1];
                            div_zero_q <= (opb == '0);
                        end else if (op_div) begin
                            illegal_q <= 1'b1;
                        end else if (i_md_op == OP_MTHI) begin
                            hi_q <= opa;
                        end else if (i_md_op == OP_MTLO) begin
                            lo_q <= opa;
                        end
                    end
                end
                S_RUN: begin
                    if (i_flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        prod_q <= prod_d;
                        cnt_q  <= cnt_q + CW'(1);
                        if (cnt_q == CW'(BITS_SIZE - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    if (!i_flush) begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_hi      = hi_q;
    assign o_lo      = lo_q;
    assign o_busy    = (state_q != S_IDLE);
    assign o_done    = done_q;
    assign o_illegal = illegal_q;
    // Held low during reset so the pipeline is free the moment reset lifts.
    assign o_stall   = i_reset &&
                       (o_busy || (i_start && (op_mul || op_div_en) && (state_q == S_IDLE)));

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed table-driven bench for ex_muldiv
module tb_ex_muldiv;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, flush;
    logic [2:0]  md_op, sel_a, sel_b;
    logic [31:0] r1, r2, exm, wbd;
    logic [31:0] hi, lo;
    logic        busy, stall, done, illegal;

    ex_muldiv #(.BITS_SIZE(32), .BITS_CORTOCIRCUITO(3), .BITS_MDOP(3)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_md_op(md_op),
        .i_corto_register_A(sel_a), .i_corto_register_B(sel_b),
        .i_register1(r1), .i_register2(r2),
        .i_exmem_register(exm), .i_wb_data_write(wbd), .i_flush(flush),
        .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_stall(stall),
        .o_done(done), .o_illegal(illegal)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  sa, sb;
        logic [31:0] r1, r2, exm, wbd;
        bit          is_long;
        bit          ill;
        logic [31:0] hi, lo;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] sa, input logic [2:0] sb,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] e, input logic [31:0] w,
                                input bit lng, input bit ill,
                                input logic [31:0] h, input logic [31:0] l);
        vec_t v;
        v.op = op; v.sa = sa; v.sb = sb; v.r1 = a; v.r2 = b; v.exm = e; v.wbd = w;
        v.is_long = lng; v.ill = ill; v.hi = h; v.lo = l;
        return v;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op = op; sel_a = 3'd0; sel_b = 3'd0; r1 = a; r2 = b;
    endtask

    // Counts negedges with busy high, leaving us at the first idle negedge.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int cyc;
        @(negedge clk);
        md_op = v.op; sel_a = v.sa; sel_b = v.sb;
        r1 = v.r1; r2 = v.r2; exm = v.exm; wbd = v.wbd;
        start = 1'b1;
        #1;
        check($sformatf("v%0d stall_req", i), {31'd0, stall}, {31'd0, v.is_long});
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d illegal", i), {31'd0, illegal}, {31'd0, v.ill});
        if (v.is_long) begin
            check($sformatf("v%0d stall_busy", i), {31'd0, stall}, 32'd1);
            wait_idle(cyc);
            check($sformatf("v%0d busy_cycles", i), cyc, 32'd33);
            check($sformatf("v%0d done", i), {31'd0, done}, 32'd1);
        end else begin
            check($sformatf("v%0d busy", i), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d done", i), {31'd0, done}, 32'd0);
        end
        check($sformatf("v%0d hi", i), hi, v.hi);
        check($sformatf("v%0d lo", i), lo, v.lo);
        @(negedge clk);
        check($sformatf("v%0d done_clear", i), {31'd0, done}, 32'd0);
        check($sformatf("v%0d illegal_clear", i), {31'd0, illegal}, 32'd0);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b1; start = 1'b0; flush = 1'b0;
        md_op = 3'd0; sel_a = 3'd0; sel_b = 3'd0;
        r1 = '0; r2 = '0; exm = '0; wbd = '0;

        // Vectors run in order; MT*/no-op/illegal rows expect the previous HI/LO.
        vt.push_back(mk(3'd1, 3'd0, 3'd0, 32'hFFFFFFFE, 32'h3, 0, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFA));
        vt.push_back(mk(3'd2, 3'd0, 3'd0, 32'hFFFFFFFE, 32'h3, 0, 0, 1, 0, 32'h00000002, 32'hFFFFFFFA));
        vt.push_back(mk(3'd1, 3'd1, 3'd2, 32'h0, 32'h0, 32'd4, 32'd5, 1, 0, 32'h0, 32'd20));
        vt.push_back(mk(3'd2, 3'd0, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 0, 32'hFFFFFFFE, 32'h00000001));
        vt.push_back(mk(3'd1, 3'd0, 3'd0, 32'h80000000, 32'h80000000, 0, 0, 1, 0, 32'h40000000, 32'h0));
        vt.push_back(mk(3'd1, 3'd0, 3'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 0, 32'hFFFFFFFF, 32'h80000001));
        vt.push_back(mk(3'd1, 3'd0, 3'd0, 32'hFFFFFFFB, 32'h0, 0, 0, 1, 0, 32'h0, 32'h0));
        vt.push_back(mk(3'd1, 3'd3, 3'd0, 32'd7, 32'd6, 32'd100, 32'd200, 1, 0, 32'h0, 32'd42));
        vt.push_back(mk(3'd5, 3'd2, 3'd0, 32'd1, 32'd0, 32'd2, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'd42));
        vt.push_back(mk(3'd6, 3'd1, 3'd0, 32'd1, 32'd0, 32'h12345678, 32'd3, 0, 0, 32'hDEADBEEF, 32'h12345678));
        vt.push_back(mk(3'd0, 3'd0, 3'd0, 32'd999, 32'd1, 0, 0, 0, 0, 32'hDEADBEEF, 32'h12345678));
        vt.push_back(mk(3'd7, 3'd0, 3'd0, 32'd999, 32'd1, 0, 0, 0, 0, 32'hDEADBEEF, 32'h12345678));
`ifdef MULDIV_DIVIDE_EN
        vt.push_back(mk(3'd3, 3'd0, 3'd0, 32'hFFFFFFF9, 32'd2, 0, 0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFD));
        vt.push_back(mk(3'd4, 3'd0, 3'd0, 32'd5, 32'd0, 0, 0, 1, 0, 32'h00000005, 32'hFFFFFFFF));
        vt.push_back(mk(3'd3, 3'd0, 3'd0, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1, 0, 32'h0, 32'h80000000));
        vt.push_back(mk(3'd3, 3'd0, 3'd0, 32'd7, 32'hFFFFFFFE, 0, 0, 1, 0, 32'h1, 32'hFFFFFFFD));
        vt.push_back(mk(3'd3, 3'd0, 3'd0, 32'hFFFFFFF8, 32'd0, 0, 0, 1, 0, 32'hFFFFFFF8, 32'hFFFFFFFF));
`else
        vt.push_back(mk(3'd3, 3'd0, 3'd0, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 1, 32'hDEADBEEF, 32'h12345678));
        vt.push_back(mk(3'd4, 3'd0, 3'd0, 32'd5, 32'd0, 0, 0, 0, 1, 32'hDEADBEEF, 32'h12345678));
`endif

        // Reset state, with a long-op request pending to show stall is held low.
        #1 rst_n = 1'b0;
        @(negedge clk);
        drive(3'd1, 32'd3, 32'd3);
        start = 1'b1;
        #1;
        check("rst stall", {31'd0, stall}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst illegal", {31'd0, illegal}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first start busy", {31'd0, busy}, 32'd1);
        wait_idle(cyc);
        check("first busy_cycles", cyc, 32'd33);
        check("first lo", lo, 32'd9);

        foreach (vt[i]) run_vec(i, vt[i]);

        // Known HI/LO before the corner sequences: 0x10000^2.
        @(negedge clk);
        drive(3'd2, 32'h10000, 32'h10000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(cyc);
        check("base hi", hi, 32'h1);
        check("base lo", lo, 32'h0);

        // Flush at RUN cycle 10: back to IDLE, HI/LO untouched, no done.
        @(negedge clk);
        drive(3'd2, 32'd9, 32'd9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-flush busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush done", {31'd0, done}, 32'd0);
        check("flush hi", hi, 32'h1);
        check("flush lo", lo, 32'h0);
        @(negedge clk);
        check("flush late done", {31'd0, done}, 32'd0);

        // Async reset at RUN cycle 5 of the next op.
        drive(3'd1, 32'd2, 32'd2);
        start = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst stall", {31'd0, stall}, 32'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("postrst busy", {31'd0, busy}, 32'd0);
        check("postrst done", {31'd0, done}, 32'd0);

        // New request while busy is ignored: result stays 3*4, cycle count 33.
        drive(3'd2, 32'd3, 32'd4);
        start = 1'b1;
        @(negedge clk);
        drive(3'd2, 32'd5, 32'd5);
        #1;
        check("busy-start stall", {31'd0, stall}, 32'd1);
        wait_idle(cyc);
        start = 1'b0;
        check("busy-start cycles", cyc, 32'd33);
        check("busy-start lo", lo, 32'd12);
        @(negedge clk);
        wait_idle(cyc);
        check("busy-start no restart", cyc, 32'd0);

        // Flush beats a simultaneous MTLO in IDLE.
        @(negedge clk);
        drive(3'd6, 32'h55, 32'd0);
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush-mtlo lo", lo, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
